core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum consecutive request cycles without ack before fault; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port opcode  input  7  instruction[6:0] from the instruction register, valid from DECODE onward.
REQ-005 SHALL have port imem_ack  input  1  instruction memory data valid.
REQ-006 SHALL have port dmem_ack  input  1  data memory access complete.
REQ-007 SHALL have port branch_taken  input  1  branch condition from the ALU, valid in EXECUTE.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port ir_we  output  1  instruction register load strobe.
REQ-010 SHALL have port dmem_req / dmem_we  output  1 each  data memory request / write qualifier.
REQ-011 SHALL have port reg_we  output  1  register file write enable, which drives need_to_write.
REQ-012 SHALL have port pc_we / pc_sel  output  1 each  PC update strobe / 1 = branch target, 0 = PC+4.
REQ-013 SHALL have port state  output  3  current state encoding.
REQ-014 SHALL have port halted / err  output  1 each  halted flag / timeout fault flag.
REQ-015 SHALL have port instret  output  32  retired instruction count.

Function
REQ-016 SHALL use states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5; codes 6 and 7 SHALL go to HALT with err=1.
REQ-017 SHALL, in FETCH, assert imem_req and drive ir_we = imem_ack combinationally; on ack -> DECODE, else stay.
REQ-018 SHALL, in DECODE, latch the opcode class into an internal register (LOAD 0000011, STORE 0100011, BRANCH 1100011, SYSTEM 1110011, else ALU) -> EXECUTE, taking 1 cycle.
REQ-019 SHALL, in EXECUTE, branch on the latched class in 1 cycle:
- BRANCH: pc_we=1, pc_sel=branch_taken -> FETCH.
- LOAD or STORE -> MEM.
- SYSTEM -> HALT with err=0.
- ALU -> WRITEBACK.
REQ-020 SHALL, in MEM, assert dmem_req, with dmem_we=1 for STORE only; on dmem_ack: LOAD -> WRITEBACK, STORE asserts pc_we (pc_sel=0) -> FETCH; else stay.
REQ-021 SHALL, in WRITEBACK, assert reg_we=1 and pc_we=1 with pc_sel=0 for exactly 1 cycle -> FETCH.
REQ-022 SHALL keep HALT until reset, with halted=1 and all strobes and requests at 0.
REQ-023 SHALL deassert every strobe (ir_we, reg_we, pc_we, dmem_we) outside the states named above; pc_sel SHALL be 0 whenever pc_we=0.
REQ-024 SHALL increment instret by 1, wrapping at 2^32, on every cycle in which pc_we=1; the SYSTEM instruction SHALL NOT be counted.
REQ-025 SHALL run a wait counter while TIMEOUT>0:
- cleared on each entry to FETCH or MEM;
- incremented each cycle imem_req or dmem_req is high without its ack;
- if the ack is low with the counter equal to TIMEOUT-1 -> HALT, err=1.
REQ-026 SHALL give ack priority if it arrives in the same cycle the timeout would fire.
REQ-027 SHALL accept an ack in the first request cycle, giving zero-wait latencies: ALU=4, BRANCH=3, STORE=4, LOAD=5 cycles.
REQ-028 SHALL ignore acks received outside the matching request state.

Reset
REQ-029 SHALL, while rst=1, immediately force state=FETCH and set halted=0, err=0, instret=0, wait counter=0, and latched class=ALU.
REQ-030 SHALL hold all strobes and requests at 0 during reset, including a reset asserted mid-MEM, where dmem_req drops without waiting for the clock.
REQ-031 SHALL assert imem_req in the first cycle after rst deasserts.

Verification
REQ-032 ALU opcode 0110011 with zero-wait imem -> state sequence 0,1,2,4,0; reg_we and pc_we high only in cycle 4; instret=1.
REQ-033 LOAD with dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; then WRITEBACK with reg_we=1; instret +1.
REQ-034 BRANCH with branch_taken=1 -> EXECUTE gives pc_we=1, pc_sel=1; next state FETCH; reg_we never asserted.
REQ-035 TIMEOUT=4 with imem_ack held 0 -> 4 cycles of imem_req, then state=5, halted=1, err=1; in a second run with ack in cycle 4 -> DECODE, err=0.
REQ-036 SYSTEM opcode 1110011 -> HALT with err=0 and instret unchanged; further imem_ack pulses have no effect.
REQ-037 rst asserted mid-MEM during a STORE -> dmem_req=0 and dmem_we=0 the same cycle; state=0 and instret=0; fetch resumes after release.

Source files
------------

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// core_sequencer : multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM
// Revision 1.0
// ============================================================================
module core_sequencer #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        reg_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic [2:0]  state,
   output logic        halted,
   output logic        err,
   output logic [31:0] instret
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU    = 3'd0,
      C_LOAD   = 3'd1,
      C_STORE  = 3'd2,
      C_BRANCH = 3'd3,
      C_SYSTEM = 3'd4
   } cls_t;

   state_t          state_q;
   cls_t            class_q;
   logic [CW-1:0]   wait_q;
   logic            err_q;
   logic [31:0]     instret_q;
   logic            w_wait_expired;

   // Ack always wins over expiry because expiry is only consulted when ack is low.
   assign w_wait_expired = (TIMEOUT > 0) && (wait_q == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         class_q   <= C_ALU;
         wait_q    <= '0;
         err_q     <= 1'b0;
         instret_q <= '0;
      end else begin
         if (pc_we) instret_q <= instret_q + 32'd1;
         case (state_q)
            S_FETCH: begin
               if (imem_ack) begin
                  wait_q  <= '0;
                  state_q <= S_DECODE;
               end else if (w_wait_expired) begin
                  state_q <= S_HALT;
                  err_q   <= 1'b1;
               end else if (TIMEOUT > 0) begin
                  wait_q  <= wait_q + 1'b1;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_LOAD:   class_q <= C_LOAD;
                  OP_STORE:  class_q <= C_STORE;
                  OP_BRANCH: class_q <= C_BRANCH;
                  OP_SYSTEM: class_q <= C_SYSTEM;
                  default:   class_q <= C_ALU;
               endcase
               state_q <= S_EXECUTE;
            end
            S_EXECUTE: begin
               wait_q <= '0;
               case (class_q)
                  C_BRANCH:        state_q <= S_FETCH;
                  C_LOAD, C_STORE: state_q <= S_MEM;
                  C_SYSTEM:        state_q <= S_HALT;
                  default:         state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               if (dmem_ack) begin
                  wait_q  <= '0;
                  state_q <= (class_q == C_STORE) ? S_FETCH : S_WB;
               end else if (w_wait_expired) begin
                  state_q <= S_HALT;
                  err_q   <= 1'b1;
               end else if (TIMEOUT > 0) begin
                  wait_q  <= wait_q + 1'b1;
               end
            end
            S_WB: begin
               wait_q  <= '0;
               state_q <= S_FETCH;
            end
            S_HALT: state_q <= S_HALT;
            default: begin
               state_q <= S_HALT;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   // Strobes are gated by rst so a reset mid-access drops them without a clock edge.
   always_comb begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ack;
            end
            S_EXECUTE: begin
               if (class_q == C_BRANCH) begin
                  pc_we  = 1'b1;
                  pc_sel = branch_taken;
               end
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (class_q == C_STORE);
               pc_we    = (class_q == C_STORE) && dmem_ack;
            end
            S_WB: begin
               reg_we = 1'b1;
               pc_we  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign err     = err_q;
   assign instret = instret_q;

endmodule
`default_nettype wire
